// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
// Instruction-fetch stage between the PC register and the IF/ID register.
// Issues one instruction-memory read at a time over a req/ack handshake and
// queues returned words together with their fetch address in a small FIFO.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   pc_i, ce_i      fetch address and fetch enable from the PC register
//   flush_i         branch taken: drop queued and in-flight fetches
//   stallreq_o      hold the PC until the current fetch is pushed (combinational)
//   mem_req_o       registered read request to instruction memory
//   mem_addr_o      registered read address
//   mem_ack_i       read data valid this cycle
//   mem_data_i      read data
//   id_ready_i      downstream accepts the head entry this cycle
//   inst_valid_o    FIFO non-empty
//   inst_o          head instruction (0 when empty)
//   inst_pc_o       head instruction's address (0 when empty)
module if_fetch_buffer #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              id_ready_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,  // request outstanding, result kept
    StDiscard = 2'd2   // request outstanding, result dropped after a flush
  } state_e;

  state_e            r_state, w_state_d;
  logic              r_mem_req, w_mem_req_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic [CntW-1:0]   r_count;
  logic [PtrW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

  logic w_issue, w_push, w_pop, w_not_empty;

  assign w_not_empty = (r_count != '0);
  assign w_issue     = (r_state == StIdle) && ce_i && !flush_i && (r_count < CntW'(DEPTH));
  assign w_push      = (r_state == StWait) && mem_ack_i && !flush_i;
  assign w_pop       = w_not_empty && id_ready_i;

  // The PC may advance exactly when its fetch is pushed, or on a branch load.
  assign stallreq_o  = ce_i && !flush_i && !((r_state == StWait) && mem_ack_i);

  // ---------------------------------------------------------------------------
  // Fetch control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d    = r_state;
    w_mem_req_d  = r_mem_req;
    w_mem_addr_d = r_mem_addr;
    unique case (r_state)
      StIdle: begin
        if (w_issue) begin
          w_state_d    = StWait;
          w_mem_req_d  = 1'b1;
          w_mem_addr_d = pc_i;
        end
      end
      StWait: begin
        if (mem_ack_i) begin
          w_state_d   = StIdle;
          w_mem_req_d = 1'b0;
        end else if (flush_i) begin
          w_state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (mem_ack_i) begin
          w_state_d   = StIdle;
          w_mem_req_d = 1'b0;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_d;
      r_mem_req  <= w_mem_req_d;
      r_mem_addr <= w_mem_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping; a flush overrides any same-cycle push or pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= mem_data_i;
      r_pc_mem[r_wr_ptr]   <= r_mem_addr;
    end
  end

  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = r_mem_addr;
  assign inst_valid_o = w_not_empty;
  assign inst_o       = w_not_empty ? r_data_mem[r_rd_ptr] : '0;
  assign inst_pc_o    = w_not_empty ? r_pc_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed testbench for if_fetch_buffer. Inputs change 1 ns after the rising
// edge; outputs are sampled 3 ns after the edge, well away from it.
module tb_if_fetch_buffer;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_i;
  logic              ce_i;
  logic              flush_i;
  logic              stallreq_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              id_ready_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  int n_vec;
  int n_err;

  if_fetch_buffer #(
    .DEPTH (2),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .flush_i     (flush_i),
    .stallreq_o  (stallreq_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i),
    .id_ready_i  (id_ready_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    pc_i       = '0;
    ce_i       = 1'b0;
    flush_i    = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    id_ready_i = 1'b0;
    next_cyc();
    next_cyc();

    // Reset state
    settle();
    check("rst_req",   mem_req_o,    0);
    check("rst_addr",  mem_addr_o,   0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst",  inst_o,       0);
    check("rst_pc",    inst_pc_o,    0);
    check("rst_stall", stallreq_o,   0);

    // Basic fetch of 0x0 with ack in the first wait cycle
    rst  = 1'b0;
    ce_i = 1'b1;
    pc_i = 32'h0;
    settle();
    check("f0_idle_stall", stallreq_o, 1);
    next_cyc();
    settle();
    check("f0_req",  mem_req_o,  1);
    check("f0_addr", mem_addr_o, 32'h0);
    check("f0_stall_noack", stallreq_o, 1);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h3C01_1234;
    settle();
    check("f0_stall_ack", stallreq_o, 0);
    next_cyc();
    mem_ack_i = 1'b0;
    pc_i      = 32'h4;
    settle();
    check("f0_valid", inst_valid_o, 1);
    check("f0_inst",  inst_o,       32'h3C01_1234);
    check("f0_ipc",   inst_pc_o,    32'h0);
    check("f0_req_drop", mem_req_o, 0);
    check("f0_stall_idle", stallreq_o, 1);

    // Second fetch of 0x4 fills the FIFO (id_ready low)
    next_cyc();
    settle();
    check("f4_req",  mem_req_o,  1);
    check("f4_addr", mem_addr_o, 32'h4);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h2042_0001;
    next_cyc();
    mem_ack_i = 1'b0;
    pc_i      = 32'h8;
    settle();
    check("full_req0",   mem_req_o,  0);
    check("full_stall0", stallreq_o, 1);
    next_cyc();
    settle();
    check("full_req1",   mem_req_o,  0);
    check("full_stall1", stallreq_o, 1);
    check("full_head",   inst_pc_o,  32'h0);

    // One-cycle pop of 0x0, then 0x8 issues
    id_ready_i = 1'b1;
    next_cyc();
    id_ready_i = 1'b0;
    settle();
    check("pop_head_pc",   inst_pc_o, 32'h4);
    check("pop_head_inst", inst_o,    32'h2042_0001);
    check("pop_req",       mem_req_o, 0);
    next_cyc();
    settle();
    check("f8_req",  mem_req_o,  1);
    check("f8_addr", mem_addr_o, 32'h8);

    // Ack delayed to the 4th wait cycle; request held stable meanwhile
    for (int i = 0; i < 3; i++) begin
      check("dly_req",   mem_req_o,  1);
      check("dly_addr",  mem_addr_o, 32'h8);
      check("dly_stall", stallreq_o, 1);
      next_cyc();
      settle();
    end
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h8C22_0008;
    settle();
    check("dly_req_ack",   mem_req_o,  1);
    check("dly_addr_ack",  mem_addr_o, 32'h8);
    check("dly_stall_ack", stallreq_o, 0);
    next_cyc();
    mem_ack_i = 1'b0;
    pc_i      = 32'hC;

    // Pop 0x4 with a simultaneous-free IDLE cycle (FIFO full, no issue)
    id_ready_i = 1'b1;
    next_cyc();
    id_ready_i = 1'b0;
    settle();
    check("pop2_head_pc",   inst_pc_o, 32'h8);
    check("pop2_head_inst", inst_o,    32'h8C22_0008);

    // Fetch 0xC issues, then flush without ack while one entry is queued
    next_cyc();
    settle();
    check("fc_addr", mem_addr_o, 32'hC);
    flush_i = 1'b1;
    pc_i    = 32'h100;
    settle();
    check("fl_stall", stallreq_o, 0);
    next_cyc();
    flush_i = 1'b0;
    settle();
    check("fl_valid", inst_valid_o, 0);
    check("fl_inst",  inst_o,       0);
    check("fl_req_held", mem_req_o, 1);
    check("fl_addr_held", mem_addr_o, 32'hC);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    settle();
    check("disc_stall_ack", stallreq_o, 1);
    next_cyc();
    mem_ack_i = 1'b0;
    settle();
    check("disc_valid", inst_valid_o, 0);
    check("disc_req",   mem_req_o,    0);
    next_cyc();
    settle();
    check("f100_req",  mem_req_o,  1);
    check("f100_addr", mem_addr_o, 32'h100);

    // Flush coincident with ack: data dropped, back to IDLE
    flush_i    = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h1111_1111;
    next_cyc();
    flush_i   = 1'b0;
    mem_ack_i = 1'b0;
    settle();
    check("flack_valid", inst_valid_o, 0);
    check("flack_req",   mem_req_o,    0);
    next_cyc();
    settle();
    check("flack_reissue", mem_req_o, 1);

    // Reset mid-WAIT; later ack is ignored
    rst = 1'b1;
    next_cyc();
    rst        = 1'b0;
    ce_i       = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h0000_0055;
    settle();
    check("mrst_req",  mem_req_o,  0);
    check("mrst_addr", mem_addr_o, 0);
    next_cyc();
    mem_ack_i = 1'b0;
    settle();
    check("mrst_valid", inst_valid_o, 0);
    check("mrst_inst",  inst_o,       0);
    check("mrst_pc",    inst_pc_o,    0);
    check("mrst_req2",  mem_req_o,    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
